// File: rtl/i2s_dac_serializer_pkg.sv
// Shared constants and helpers for the I2S DAC serializer slice.
// Holds the default sample width, FIFO depth, word-select encoding and pointer sizing.
package i2s_dac_serializer_pkg;

  localparam int SAMPLE_W_DEFAULT   = 24;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  // Word-select levels on AUD_DACLRCK.
  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  // Pointer width for a power-of-two FIFO; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dac_frame_fifo.sv
// First-word-fall-through frame FIFO for the I2S DAC serializer.
// Stores {left, right} stereo frames; full and empty come from registered occupancy.
module dac_frame_fifo
  import i2s_dac_serializer_pkg::*;
#(
  parameter int WIDTH = 2 * SAMPLE_W_DEFAULT,
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/i2s_dac_serializer.sv
// I2S DAC serializer: buffers stereo frames and shifts them out MSB-first on AUD_DACDAT,
// driven by CODEC-supplied BCLK/LRCK that are treated purely as asynchronous data.
module i2s_dac_serializer
  import i2s_dac_serializer_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int DEPTH    = FIFO_DEPTH_DEFAULT
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                write,
  input  logic [SAMPLE_W-1:0] writedata_left,
  input  logic [SAMPLE_W-1:0] writedata_right,
  output logic                write_ready,
  input  logic                AUD_BCLK,
  input  logic                AUD_DACLRCK,
  output logic                AUD_DACDAT,
  output logic                underflow
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);

  logic                  bclk_s1, bclk_s2, bclk_s3;
  logic                  lr_s1, lr_s2;
  logic                  lr_prev;
  logic                  fe;
  logic                  word_start;
  logic                  left_start;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [2*SAMPLE_W-1:0] fifo_dout;
  logic [SAMPLE_W-1:0]   shift_reg;
  logic [SAMPLE_W-1:0]   right_hold;
  logic [CNT_W-1:0]      bit_cnt;

  // Two synchronizer flops each; bclk_s3 is the BCLK edge-detect flop, and lr_prev,
  // updated only on BCLK falls, is the edge-detect flop for LRCK.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bclk_s1 <= 1'b0;
      bclk_s2 <= 1'b0;
      bclk_s3 <= 1'b0;
      lr_s1   <= 1'b0;
      lr_s2   <= 1'b0;
    end else begin
      bclk_s1 <= AUD_BCLK;
      bclk_s2 <= bclk_s1;
      bclk_s3 <= bclk_s2;
      lr_s1   <= AUD_DACLRCK;
      lr_s2   <= lr_s1;
    end
  end

  assign fe         = bclk_s3 & ~bclk_s2;
  assign word_start = fe & (lr_s2 != lr_prev);
  assign left_start = word_start & (lr_s2 == LR_LEFT);
  assign fifo_pop   = left_start & ~fifo_empty;

  assign write_ready = ~fifo_full;

  dac_frame_fifo #(
    .WIDTH (2 * SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50),
    .reset (reset),
    .push  (write),
    .pop   (fifo_pop),
    .din   ({writedata_left, writedata_right}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      lr_prev    <= 1'b1;
      shift_reg  <= '0;
      right_hold <= '0;
      bit_cnt    <= '0;
      AUD_DACDAT <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (fe) begin
        lr_prev <= lr_s2;
        if (word_start) begin
          // A word start always reloads, so a short frame simply aborts the old word.
          AUD_DACDAT <= 1'b0;
          bit_cnt    <= CNT_W'(SAMPLE_W);
          if (lr_s2 == LR_LEFT) begin
            if (fifo_empty) begin
              shift_reg  <= '0;
              right_hold <= '0;
              underflow  <= 1'b1;
            end else begin
              shift_reg  <= fifo_dout[2*SAMPLE_W-1:SAMPLE_W];
              right_hold <= fifo_dout[SAMPLE_W-1:0];
            end
          end else begin
            shift_reg <= right_hold;
          end
        end else if (bit_cnt != '0) begin
          AUD_DACDAT <= shift_reg[SAMPLE_W-1];
          shift_reg  <= {shift_reg[SAMPLE_W-2:0], 1'b0};
          bit_cnt    <= bit_cnt - 1'b1;
        end else begin
          AUD_DACDAT <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Directed testbench for i2s_dac_serializer: BCLK = CLOCK_50/16, LRCK = BCLK/64,
// DACDAT sampled 4 CLOCK_50 cycles after each BCLK fall and compared to hand-built words.
module tb_i2s_dac_serializer;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        write;
  logic [23:0] writedata_left;
  logic [23:0] writedata_right;
  logic        write_ready;
  logic        AUD_BCLK;
  logic        AUD_DACLRCK;
  logic        AUD_DACDAT;
  logic        underflow;

  int tests = 0;
  int fails = 0;
  int uf_count = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  i2s_dac_serializer #(
    .SAMPLE_W (24),
    .DEPTH    (4)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .write_ready     (write_ready),
    .AUD_BCLK        (AUD_BCLK),
    .AUD_DACLRCK     (AUD_DACLRCK),
    .AUD_DACDAT      (AUD_DACDAT),
    .underflow       (underflow)
  );

  always @(negedge CLOCK_50) if (underflow === 1'b1) uf_count++;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input logic [23:0] l, input logic [23:0] r);
    @(negedge CLOCK_50);
    write = 1'b1; writedata_left = l; writedata_right = r;
    @(negedge CLOCK_50);
    write = 1'b0;
  endtask

  task automatic bclk_bit(input logic lr, output logic b);
    @(negedge CLOCK_50);
    AUD_BCLK = 1'b0; AUD_DACLRCK = lr;
    repeat (4) @(negedge CLOCK_50);
    b = AUD_DACDAT;
    repeat (4) @(negedge CLOCK_50);
    AUD_BCLK = 1'b1;
    repeat (7) @(negedge CLOCK_50);
  endtask

  task automatic run_half(input logic lr, output logic [31:0] bits);
    logic b;
    bits = '0;
    for (int i = 0; i < 32; i++) begin
      bclk_bit(lr, b);
      bits = {bits[30:0], b};
    end
  endtask

  task automatic run_frame(output logic [31:0] l, output logic [31:0] r);
    run_half(1'b0, l);
    run_half(1'b1, r);
  endtask

  task automatic test_reset;
    reset = 1'b1; write = 1'b0; writedata_left = '0; writedata_right = '0;
    AUD_BCLK = 1'b1; AUD_DACLRCK = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    tests++; if (write_ready !== 1'b1) begin fails++; $display("FAIL reset_write_ready: got %b expected 1", write_ready); end
    tests++; if (AUD_DACDAT !== 1'b0) begin fails++; $display("FAIL reset_dacdat: got %b expected 0", AUD_DACDAT); end
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic test_basic;
    logic [31:0] l, r;
    logic [23:0] el, er;
    int uf0;
    el = 24'hA5A5A5; er = 24'h3C3C3C;
    push_frame(el, er);
    uf0 = uf_count;
    run_frame(l, r);
    tests++; if (l !== {1'b0, el, 7'b0}) begin fails++; $display("FAIL basic_left: got %h expected %h", l, {1'b0, el, 7'b0}); end
    tests++; if (r !== {1'b0, er, 7'b0}) begin fails++; $display("FAIL basic_right: got %h expected %h", r, {1'b0, er, 7'b0}); end
    tests++; if (uf_count !== uf0) begin fails++; $display("FAIL basic_no_underflow: got %0d expected %0d", uf_count, uf0); end
  endtask

  task automatic test_full;
    logic [23:0] fl [5];
    logic [23:0] fr [5];
    logic [31:0] l, r;
    logic b;
    int uf0;
    for (int k = 0; k < 5; k++) begin
      fl[k] = 24'h111111 * (k + 1);
      fr[k] = ~fl[k];
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge CLOCK_50);
      tests++;
      if (write_ready !== (k < 4)) begin fails++; $display("FAIL full_ready_before_%0d: got %b expected %b", k, write_ready, (k < 4)); end
      write = 1'b1; writedata_left = fl[k]; writedata_right = fr[k];
    end
    @(negedge CLOCK_50);
    write = 1'b0;
    tests++; if (write_ready !== 1'b0) begin fails++; $display("FAIL full_ready_after: got %b expected 0", write_ready); end
    // Left start with a full FIFO: ready comes back the cycle after the pop.
    AUD_BCLK = 1'b0; AUD_DACLRCK = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    tests++; if (write_ready !== 1'b0) begin fails++; $display("FAIL full_ready_pre_pop: got %b expected 0", write_ready); end
    @(negedge CLOCK_50);
    tests++; if (write_ready !== 1'b1) begin fails++; $display("FAIL full_ready_post_pop: got %b expected 1", write_ready); end
    @(negedge CLOCK_50);
    b = AUD_DACDAT;
    repeat (4) @(negedge CLOCK_50);
    AUD_BCLK = 1'b1;
    repeat (7) @(negedge CLOCK_50);
    l = {31'b0, b};
    for (int i = 1; i < 32; i++) begin
      bclk_bit(1'b0, b);
      l = {l[30:0], b};
    end
    run_half(1'b1, r);
    tests++; if (l !== {1'b0, fl[0], 7'b0}) begin fails++; $display("FAIL full_frame0_left: got %h expected %h", l, {1'b0, fl[0], 7'b0}); end
    tests++; if (r !== {1'b0, fr[0], 7'b0}) begin fails++; $display("FAIL full_frame0_right: got %h expected %h", r, {1'b0, fr[0], 7'b0}); end
    for (int k = 1; k < 4; k++) begin
      run_frame(l, r);
      tests++; if (l !== {1'b0, fl[k], 7'b0}) begin fails++; $display("FAIL full_frame%0d_left: got %h expected %h", k, l, {1'b0, fl[k], 7'b0}); end
      tests++; if (r !== {1'b0, fr[k], 7'b0}) begin fails++; $display("FAIL full_frame%0d_right: got %h expected %h", k, r, {1'b0, fr[k], 7'b0}); end
    end
    uf0 = uf_count;
    run_frame(l, r);
    tests++; if (uf_count !== uf0 + 1) begin fails++; $display("FAIL full_fifth_ignored_uf: got %0d expected %0d", uf_count, uf0 + 1); end
    tests++; if ({l, r} !== 64'h0) begin fails++; $display("FAIL full_fifth_ignored_data: got %h expected 0", {l, r}); end
  endtask

  task automatic test_underflow;
    logic [31:0] l, r;
    int uf0;
    uf0 = uf_count;
    run_frame(l, r);
    tests++; if (uf_count !== uf0 + 1) begin fails++; $display("FAIL uf_pulse_count: got %0d expected %0d", uf_count, uf0 + 1); end
    tests++; if ({l, r} !== 64'h0) begin fails++; $display("FAIL uf_zero_frame: got %h expected 0", {l, r}); end
    push_frame(24'h800001, 24'h7FFFFE);
    uf0 = uf_count;
    run_frame(l, r);
    tests++; if (l !== 32'h40000080) begin fails++; $display("FAIL uf_recover_left: got %h expected 40000080", l); end
    tests++; if (r !== 32'h3FFFFF00) begin fails++; $display("FAIL uf_recover_right: got %h expected 3fffff00", r); end
    tests++; if (uf_count !== uf0) begin fails++; $display("FAIL uf_recover_no_uf: got %0d expected %0d", uf_count, uf0); end
  endtask

  task automatic test_push_at_left_start;
    logic [31:0] l, r;
    logic b;
    int uf0;
    uf0 = uf_count;
    @(negedge CLOCK_50);
    AUD_BCLK = 1'b0; AUD_DACLRCK = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    write = 1'b1; writedata_left = 24'h13579B; writedata_right = 24'h2468AC;
    @(negedge CLOCK_50);
    write = 1'b0;
    tests++; if (write_ready !== 1'b1) begin fails++; $display("FAIL same_cycle_ready: got %b expected 1", write_ready); end
    @(negedge CLOCK_50);
    b = AUD_DACDAT;
    repeat (4) @(negedge CLOCK_50);
    AUD_BCLK = 1'b1;
    repeat (7) @(negedge CLOCK_50);
    l = {31'b0, b};
    for (int i = 1; i < 32; i++) begin
      bclk_bit(1'b0, b);
      l = {l[30:0], b};
    end
    run_half(1'b1, r);
    tests++; if (uf_count !== uf0 + 1) begin fails++; $display("FAIL same_cycle_uf: got %0d expected %0d", uf_count, uf0 + 1); end
    tests++; if ({l, r} !== 64'h0) begin fails++; $display("FAIL same_cycle_zero: got %h expected 0", {l, r}); end
    run_frame(l, r);
    tests++; if (l !== 32'h09ABCD80) begin fails++; $display("FAIL same_cycle_next_left: got %h expected 09abcd80", l); end
    tests++; if (r !== 32'h12345600) begin fails++; $display("FAIL same_cycle_next_right: got %h expected 12345600", r); end
  endtask

  task automatic test_reset_mid_word;
    logic [31:0] l, r;
    logic b;
    int uf0;
    for (int k = 0; k < 4; k++) push_frame(24'hFFFFFF, 24'hFFFFFF);
    for (int i = 0; i < 10; i++) bclk_bit(1'b0, b);
    push_frame(24'hFFFFFF, 24'hFFFFFF);
    tests++; if (write_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_pre_ready: got %b expected 0", write_ready); end
    @(negedge CLOCK_50); reset = 1'b1;
    @(negedge CLOCK_50); reset = 1'b0;
    tests++; if (AUD_DACDAT !== 1'b0) begin fails++; $display("FAIL rst_mid_dacdat: got %b expected 0", AUD_DACDAT); end
    tests++; if (write_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b expected 1", write_ready); end
    uf0 = uf_count;
    run_frame(l, r);
    tests++; if (uf_count !== uf0 + 1) begin fails++; $display("FAIL rst_mid_uf: got %0d expected %0d", uf_count, uf0 + 1); end
    tests++; if ({l, r} !== 64'h0) begin fails++; $display("FAIL rst_mid_zero: got %h expected 0", {l, r}); end
  endtask

  task automatic test_abort;
    logic [9:0]  short;
    logic [31:0] l, r;
    logic b;
    int uf0;
    push_frame(24'hABCDEF, 24'h123456);
    push_frame(24'hFEDCBA, 24'h654321);
    uf0 = uf_count;
    short = '0;
    for (int i = 0; i < 10; i++) begin
      bclk_bit(1'b0, b);
      short = {short[8:0], b};
    end
    run_half(1'b1, r);
    tests++; if (short !== 10'b0101010111) begin fails++; $display("FAIL abort_short_left: got %b expected 0101010111", short); end
    tests++; if (r !== 32'h091A2B00) begin fails++; $display("FAIL abort_right: got %h expected 091a2b00", r); end
    run_frame(l, r);
    tests++; if (l !== 32'h7F6E5D00) begin fails++; $display("FAIL abort_next_left: got %h expected 7f6e5d00", l); end
    tests++; if (r !== 32'h32A19080) begin fails++; $display("FAIL abort_next_right: got %h expected 32a19080", r); end
    tests++; if (uf_count !== uf0) begin fails++; $display("FAIL abort_no_uf: got %0d expected %0d", uf_count, uf0); end
    run_frame(l, r);
    tests++; if (uf_count !== uf0 + 1) begin fails++; $display("FAIL abort_drained_uf: got %0d expected %0d", uf_count, uf0 + 1); end
    tests++; if (write_ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b expected 1", write_ready); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full;
    test_underflow;
    test_push_at_left_start;
    test_reset_mid_word;
    test_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
